// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//
// Decodes the format of an RV32 instruction word, builds its sign-extended
// immediate, and queues {imm, fmt, tag} in a 2-entry in-order buffer.
// The decode is combinational at the input. Results leave from the
// registered head entry, so the minimum latency is one cycle.
//
// Handshake: a transfer happens on a side in any cycle where valid && ready
// are both high on that side. in_ready is derived only from the registered
// buffer state and never from out_ready. While out_valid=1 and
// out_ready=0, imm/fmt/out_tag are held unchanged.
//
// Parameters
//   XLEN       immediate width, 32 or 64
//   TAGW       sideband tag width; the tag is carried unmodified
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream offers instr/in_tag
//   in_ready   block can accept (buffer not full)
//   instr      RV32 instruction word
//   in_tag     sideband tag accompanying instr
//   out_valid  head entry holds a result
//   out_ready  downstream consumes the head this cycle
//   imm        sign-extended immediate of the head entry
//   fmt        format code of the head entry: R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//   out_tag    tag of the head entry
//   state_dbg  buffer state: 0=EMPTY 1=ONE 2=TWO
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int TAGW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [TAGW-1:0] out_tag,
  output logic [1:0]      state_dbg
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------
  logic [2:0]      dec_fmt;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_fmt   = FMT_ILL;
    dec_imm32 = 32'd0;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt   = FMT_R;
        dec_imm32 = 32'd0;
      end
      default: begin
        dec_fmt   = FMT_ILL;
        dec_imm32 = 32'd0;
      end
    endcase
  end

  // Widen the 32-bit immediate to XLEN. The replication count is never
  // zero, so the same expression works for XLEN=32 and XLEN=64.
  assign dec_imm = {{(XLEN-31){dec_imm32[31]}}, dec_imm32[30:0]};

  // ---------------------------------------------------------------------
  // Two-entry buffer: slot 0 is always the head, slot 1 the entry behind it
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [XLEN-1:0] imm0_q, imm0_d, imm1_q, imm1_d;
  logic [2:0]      fmt0_q, fmt0_d, fmt1_q, fmt1_d;
  logic [TAGW-1:0] tag0_q, tag0_d, tag1_q, tag1_d;

  logic push;
  logic pop;

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    imm0_d  = imm0_q;
    fmt0_d  = fmt0_q;
    tag0_d  = tag0_q;
    imm1_d  = imm1_q;
    fmt1_d  = fmt1_q;
    tag1_d  = tag1_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          imm0_d  = dec_imm;
          fmt0_d  = dec_fmt;
          tag0_d  = in_tag;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          // The head leaves and the new entry replaces it directly.
          imm0_d = dec_imm;
          fmt0_d = dec_fmt;
          tag0_d = in_tag;
        end else if (push) begin
          imm1_d  = dec_imm;
          fmt1_d  = dec_fmt;
          tag1_d  = in_tag;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          imm0_d  = imm1_q;
          fmt0_d  = fmt1_q;
          tag0_d  = tag1_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      imm0_q  <= '0;
      fmt0_q  <= '0;
      tag0_q  <= '0;
      imm1_q  <= '0;
      fmt1_q  <= '0;
      tag1_q  <= '0;
    end else begin
      state_q <= state_d;
      imm0_q  <= imm0_d;
      fmt0_q  <= fmt0_d;
      tag0_q  <= tag0_d;
      imm1_q  <= imm1_d;
      fmt1_q  <= fmt1_d;
      tag1_q  <= tag1_d;
    end
  end

  assign imm       = imm0_q;
  assign fmt       = fmt0_q;
  assign out_tag   = tag0_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed testbench for imm_gen_pipe. It uses a 32-bit instance for the
// bulk of the scenarios and a 64-bit instance for sign extension to XLEN=64.
module tb_imm_gen_pipe;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, in_tag, imm, out_tag;
  logic [2:0]  fmt;
  logic [1:0]  state_dbg;

  // 64-bit instance
  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [31:0] instr64, in_tag64, out_tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [1:0]  state_dbg64;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  imm_gen_pipe #(.XLEN(32), .TAGW(32)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .fmt       (fmt),
    .out_tag   (out_tag),
    .state_dbg (state_dbg)
  );

  imm_gen_pipe #(.XLEN(64), .TAGW(32)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .instr     (instr64),
    .in_tag    (in_tag64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .imm       (imm64),
    .fmt       (fmt64),
    .out_tag   (out_tag64),
    .state_dbg (state_dbg64)
  );

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Advance one clock edge and settle just after it; checks and new drives
  // both happen at this point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] i_instr, input logic [31:0] i_tag);
    in_valid = 1'b1;
    instr    = i_instr;
    in_tag   = i_tag;
    step();
    in_valid = 1'b0;
    instr    = 32'hDEAD_BEEF;
    in_tag   = 32'hBAD0_BAD0;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b1;          // push coincident with reset must be dropped
    instr       = 32'hFFF00093;
    in_tag      = 32'h55;
    out_ready   = 1'b0;
    in_valid64  = 1'b0;
    instr64     = 32'd0;
    in_tag64    = 32'd0;
    out_ready64 = 1'b1;
    step();
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (imm !== 32'd0 || fmt !== 3'd0 || out_tag !== 32'd0)
      begin errors++; $display("FAIL reset_outputs got imm %h fmt %0d tag %h want 0 0 0", imm, fmt, out_tag); end
    checks++;
    if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_stale got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    push_one(32'hFFF00093, 32'h100);
    checks++;
    if (out_valid !== 1'b1 || imm !== 32'hFFFFFFFF || fmt !== 3'd1 || out_tag !== 32'h100)
      begin errors++; $display("FAIL addi got v %b imm %h fmt %0d tag %h want 1 ffffffff 1 00000100", out_valid, imm, fmt, out_tag); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4];
    logic [31:0] eimm[4];
    logic [2:0]  efmt[4];
    logic [31:0] e;
    ins[0] = 32'hFE112E23; eimm[0] = 32'hFFFFFFFC; efmt[0] = 3'd2;
    ins[1] = 32'hFE000FE3; eimm[1] = 32'hFFFFFFFE; efmt[1] = 3'd3;
    ins[2] = 32'h0010006F; eimm[2] = 32'h00000800; efmt[2] = 3'd5;
    ins[3] = 32'h123450B7; eimm[3] = 32'h12345000; efmt[3] = 3'd4;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      instr    = ins[i];
      in_tag   = 32'h200 + i;
      exp_q.push_back(eimm[i]);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
      step();
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || imm !== e || fmt !== efmt[i] || out_tag !== 32'h200 + i)
        begin errors++; $display("FAIL b2b[%0d] got v %b imm %h fmt %0d tag %h want 1 %h %0d %h", i, out_valid, imm, fmt, out_tag, e, efmt[i], 32'h200 + i); end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    out_ready = 1'b0;
    exp_q.push_back(32'h5);
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hFFFFFFFF);
    in_valid = 1'b1; instr = 32'h00500093; in_tag = 32'h300;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || imm !== 32'h5)
      begin errors++; $display("FAIL bp_first got rdy %b v %b imm %h want 1 1 00000005", in_ready, out_valid, imm); end
    instr = 32'h00A00113; in_tag = 32'h301;
    step();
    checks++;
    if (in_ready !== 1'b0 || state_dbg !== 2'd2)
      begin errors++; $display("FAIL bp_full got rdy %b state %0d want 0 2", in_ready, state_dbg); end
    instr = 32'hFFF00093; in_tag = 32'h302;   // held by upstream
    step();
    step();
    checks++;
    if (in_ready !== 1'b0 || imm !== 32'h5 || fmt !== 3'd1 || out_tag !== 32'h300)
      begin errors++; $display("FAIL bp_hold got rdy %b imm %h fmt %0d tag %h want 0 00000005 1 00000300", in_ready, imm, fmt, out_tag); end
    out_ready = 1'b1;
    step();
    e = exp_q.pop_front();
    checks++;
    if (e !== 32'h5) begin errors++; $display("FAIL bp_order got %h want 00000005", e); end
    e = exp_q.pop_front();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || imm !== e || out_tag !== 32'h301)
      begin errors++; $display("FAIL bp_pop1 got rdy %b v %b imm %h tag %h want 1 1 %h 00000301", in_ready, out_valid, imm, out_tag, e); end
    step();
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || imm !== e || out_tag !== 32'h302)
      begin errors++; $display("FAIL bp_pop2 got v %b imm %h tag %h want 1 %h 00000302", out_valid, imm, out_tag, e); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_formats();
    logic [31:0] ins [6];
    logic [31:0] eimm[6];
    logic [2:0]  efmt[6];
    ins[0] = 32'h0000007F; eimm[0] = 32'h00000000; efmt[0] = 3'd7;
    ins[1] = 32'h00208033; eimm[1] = 32'h00000000; efmt[1] = 3'd0;
    ins[2] = 32'hFFC12083; eimm[2] = 32'hFFFFFFFC; efmt[2] = 3'd1;
    ins[3] = 32'h00008067; eimm[3] = 32'h00000000; efmt[3] = 3'd1;
    ins[4] = 32'hFFFFF517; eimm[4] = 32'hFFFFF000; efmt[4] = 3'd4;
    ins[5] = 32'h7FF00073; eimm[5] = 32'h000007FF; efmt[5] = 3'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_one(ins[i], 32'h500 + i);
      checks++;
      if (out_valid !== 1'b1 || imm !== eimm[i] || fmt !== efmt[i])
        begin errors++; $display("FAIL fmt[%0d] got v %b imm %h fmt %0d want 1 %h %0d", i, out_valid, imm, fmt, eimm[i], efmt[i]); end
      step();
    end
  endtask

  task automatic test_xlen64();
    in_valid64 = 1'b1;
    instr64    = 32'h800000B7;
    in_tag64   = 32'h640;
    step();
    in_valid64 = 1'b0;
    checks++;
    if (out_valid64 !== 1'b1 || imm64 !== 64'hFFFFFFFF80000000 || fmt64 !== 3'd4 || out_tag64 !== 32'h640)
      begin errors++; $display("FAIL xlen64 got v %b imm %h fmt %0d tag %h want 1 ffffffff80000000 4 00000640", out_valid64, imm64, fmt64, out_tag64); end
    instr64  = 32'h00A00113;
    in_valid64 = 1'b1;
    step();
    in_valid64 = 1'b0;
    checks++;
    if (imm64 !== 64'h000000000000000A || fmt64 !== 3'd1)
      begin errors++; $display("FAIL xlen64_pos got imm %h fmt %0d want 000000000000000a 1", imm64, fmt64); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00100093; in_tag = 32'h700;
    step();
    instr = 32'h00200093; in_tag = 32'h701;
    step();
    in_valid = 1'b0;
    checks++;
    if (state_dbg !== 2'd2) begin errors++; $display("FAIL rmid_fill got state %0d want 2", state_dbg); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm !== 32'd0 || out_tag !== 32'd0)
      begin errors++; $display("FAIL rmid_reset got v %b rdy %b imm %h tag %h want 0 1 0 0", out_valid, in_ready, imm, out_tag); end
    out_ready = 1'b1;
    push_one(32'h00700093, 32'h400);
    checks++;
    if (out_valid !== 1'b1 || imm !== 32'h7 || out_tag !== 32'h400)
      begin errors++; $display("FAIL rmid_push got v %b imm %h tag %h want 1 00000007 00000400", out_valid, imm, out_tag); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got out_valid %b want 0", out_valid); end
  endtask

  // ---------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------
  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_formats();
    test_xlen64();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
